ps2_scan_decoder: RTL and testbench

Decodes the PS/2 Set 2 byte stream from the keyboard receiver into game-direction key state. It tracks the `E0` (extended) and `F0` (break) prefixes and maps W/A/S/D and the four arrow keys onto four directions. It sits directly downstream of the keyboard receiver and upstream of game logic. The byte stream must already be synchronised into `clk` and qualified by a one-cycle `byte_valid` pulse.

---
 rtl/ps2_scan_decoder.sv | 119 +++++++++++
 tb/tb_ps2_scan_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set 2 scan-code decoder: tracks E0/F0 prefixes and maps
// WASD and arrow keys onto four held direction bits with event pulses.
module ps2_scan_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic [3:0] key_held,
   output logic       key_event,
   output logic [1:0] event_dir,
   output logic       event_press,
   output logic       seq_error
);

   // bit0 = extended prefix seen, bit1 = break prefix seen
   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_EXT     = 2'b01;
   localparam logic [1:0] S_BRK     = 2'b10;
   localparam logic [1:0] S_EXT_BRK = 2'b11;

   localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic [23:0] cnt;
   logic        is_e0;
   logic        is_f0;
   logic        hit;
   logic [1:0]  dir;
   logic        do_make;
   logic        do_brk;
   logic        expire;
   logic        mk;
   logic        bk;

   assign is_e0 = (byte_in == 8'hE0);
   assign is_f0 = (byte_in == 8'hF0);

   always_comb begin
      hit = 1'b0;
      dir = 2'd0;
      if (state[0]) begin
         unique case (byte_in)
            8'h75:   begin hit = 1'b1; dir = 2'd0; end
            8'h72:   begin hit = 1'b1; dir = 2'd1; end
            8'h6B:   begin hit = 1'b1; dir = 2'd2; end
            8'h74:   begin hit = 1'b1; dir = 2'd3; end
            default: begin hit = 1'b0; dir = 2'd0; end
         endcase
      end else begin
         unique case (byte_in)
            8'h1D:   begin hit = 1'b1; dir = 2'd0; end
            8'h1B:   begin hit = 1'b1; dir = 2'd1; end
            8'h1C:   begin hit = 1'b1; dir = 2'd2; end
            8'h23:   begin hit = 1'b1; dir = 2'd3; end
            default: begin hit = 1'b0; dir = 2'd0; end
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      do_make  = 1'b0;
      do_brk   = 1'b0;
      if (byte_valid) begin
         unique case (state)
            S_IDLE: begin
               if (is_e0)      state_nx = S_EXT;
               else if (is_f0) state_nx = S_BRK;
               else            state_nx = S_IDLE;
               do_make = !is_e0 && !is_f0;
            end
            S_EXT: begin
               state_nx = is_f0 ? S_EXT_BRK : S_IDLE;
               do_make  = !is_f0;
            end
            default: begin
               state_nx = S_IDLE;
               do_brk   = 1'b1;
            end
         endcase
      end
   end

   // A byte arriving on the expiry cycle takes precedence
   assign expire = !byte_valid && (state != S_IDLE) &&
                   (cnt == CNT_LAST);

   assign mk = do_make && hit && !key_held[dir];
   assign bk = do_brk && hit && key_held[dir];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 24'd0;
         key_held    <= 4'b0000;
         key_event   <= 1'b0;
         event_dir   <= 2'd0;
         event_press <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         state     <= expire ? S_IDLE : state_nx;
         seq_error <= expire;
         key_event <= mk || bk;
         if (byte_valid || (state == S_IDLE) || expire)
            cnt <= 24'd0;
         else
            cnt <= cnt + 24'd1;
         if (mk || bk) begin
            key_held[dir] <= mk;
            event_dir     <= dir;
            event_press   <= mk;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed self-checking bench for ps2_scan_decoder.
// Runs with a short timeout so the expiry path is reachable.
module tb_ps2_scan_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic [3:0] key_held;
   logic       key_event;
   logic [1:0] event_dir;
   logic       event_press;
   logic       seq_error;

   int n_cmp;
   int n_bad;

   ps2_scan_decoder #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .key_held    (key_held),
      .key_event   (key_event),
      .event_dir   (event_dir),
      .event_press (event_press),
      .seq_error   (seq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // byte sampled at the next rising edge; returns at the following
   // falling edge, where that byte's result is visible
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'h00;
   endtask

   task automatic ev(input string tag, input logic [3:0] held,
                     input logic e, input logic [1:0] d,
                     input logic p);
      chk({tag, ".held"}, {4'b0, key_held}, {4'b0, held});
      chk({tag, ".event"}, {7'b0, key_event}, {7'b0, e});
      if (e) begin
         chk({tag, ".dir"}, {6'b0, event_dir}, {6'b0, d});
         chk({tag, ".press"}, {7'b0, event_press}, {7'b0, p});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.held", {4'b0, key_held}, 8'h00);
      chk("rst.event", {7'b0, key_event}, 8'h00);
      chk("rst.dir", {6'b0, event_dir}, 8'h00);
      chk("rst.press", {7'b0, event_press}, 8'h00);
      chk("rst.seqerr", {7'b0, seq_error}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'h1D); ev("w_make", 4'b0001, 1'b1, 2'd0, 1'b1);
      @(negedge clk);
      chk("w_make.pulse1", {7'b0, key_event}, 8'h00);
      send(8'hF0); ev("w_pfx", 4'b0001, 1'b0, 2'd0, 1'b0);
      send(8'h1D); ev("w_brk", 4'b0000, 1'b1, 2'd0, 1'b0);

      send(8'hE0); ev("rt_e0", 4'b0000, 1'b0, 2'd0, 1'b0);
      send(8'h74); ev("rt_make", 4'b1000, 1'b1, 2'd3, 1'b1);
      send(8'hE0); ev("rt_e0b", 4'b1000, 1'b0, 2'd0, 1'b0);
      send(8'hF0); ev("rt_f0", 4'b1000, 1'b0, 2'd0, 1'b0);
      send(8'h74); ev("rt_brk", 4'b0000, 1'b1, 2'd3, 1'b0);

      send(8'h1C); ev("a_make1", 4'b0100, 1'b1, 2'd2, 1'b1);
      send(8'h1C); ev("a_rep2", 4'b0100, 1'b0, 2'd0, 1'b0);
      send(8'h1C); ev("a_rep3", 4'b0100, 1'b0, 2'd0, 1'b0);
      send(8'hF0); ev("a_f0", 4'b0100, 1'b0, 2'd0, 1'b0);
      send(8'h1C); ev("a_brk", 4'b0000, 1'b1, 2'd2, 1'b0);

      send(8'h1D); ev("sh_w", 4'b0001, 1'b1, 2'd0, 1'b1);
      send(8'hE0); ev("sh_e0", 4'b0001, 1'b0, 2'd0, 1'b0);
      send(8'h75); ev("sh_up", 4'b0001, 1'b0, 2'd0, 1'b0);
      send(8'hE0); ev("sh_e0b", 4'b0001, 1'b0, 2'd0, 1'b0);
      send(8'hF0); ev("sh_f0", 4'b0001, 1'b0, 2'd0, 1'b0);
      send(8'h75); ev("sh_brk", 4'b0000, 1'b1, 2'd0, 1'b0);

      send(8'hAA); ev("unmapped", 4'b0000, 1'b0, 2'd0, 1'b0);

      // F0 at edge N; seq_error visible after edge N+16
      send(8'hF0);
      repeat (15) @(negedge clk);
      chk("to.early", {7'b0, seq_error}, 8'h00);
      @(negedge clk);
      chk("to.pulse", {7'b0, seq_error}, 8'h01);
      chk("to.held", {4'b0, key_held}, 8'h00);
      @(negedge clk);
      chk("to.pulse1", {7'b0, seq_error}, 8'h00);
      send(8'h23); ev("to.d_make", 4'b1000, 1'b1, 2'd3, 1'b1);

      // next byte lands on the expiry edge N+16
      send(8'hF0);
      repeat (14) @(negedge clk);
      send(8'h23); ev("race.brk", 4'b0000, 1'b1, 2'd3, 1'b0);
      chk("race.noerr", {7'b0, seq_error}, 8'h00);
      @(negedge clk);
      chk("race.noerr2", {7'b0, seq_error}, 8'h00);

      send(8'h1B); ev("rs_s", 4'b0010, 1'b1, 2'd1, 1'b1);
      send(8'h23); ev("rs_d", 4'b1010, 1'b1, 2'd3, 1'b1);
      send(8'hE0); ev("rs_e0", 4'b1010, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rs.held", {4'b0, key_held}, 8'h00);
      chk("rs.dir", {6'b0, event_dir}, 8'h00);
      chk("rs.press", {7'b0, event_press}, 8'h00);
      chk("rs.event", {7'b0, key_event}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h75); ev("rs_bare75", 4'b0000, 1'b0, 2'd0, 1'b0);
      send(8'hE0); ev("rs_e0b", 4'b0000, 1'b0, 2'd0, 1'b0);
      send(8'h75); ev("rs_up", 4'b0001, 1'b1, 2'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
